sat_accum_16bit: RTL
====================

SAT_ACCUM_16BIT -- requirements
Module: sat_accum_16bit

Interface
REQ-001 Parameter LEN_W, default 4: width of operand-count field; one job accepts up to 2^LEN_W operands.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  job request; sampled only in IDLE.
REQ-005 len  input  LEN_W  operand count for the job, captured with start; 0 encodes 2^LEN_W.
REQ-006 in_valid  input  1  operand present on in_data/in_sub.
REQ-007 in_ready  output  1  block accepts an operand this cycle.
REQ-008 in_data  input  16  two's-complement operand.
REQ-009 in_sub  input  1  1 = acc minus in_data; 0 = acc plus in_data.
REQ-010 out_valid  output  1  job result is valid on acc/ovfl.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 acc  output  16  running or final saturated accumulator.
REQ-013 ovfl  output  1  sticky: set if any step of the current job saturated.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ACCUM and DONE, encoded in registers.
REQ-016 IDLE: in_ready=0, out_valid=0; start=1 -> acc<=0, ovfl<=0, remaining<=len (0 maps to 2^LEN_W), next ACCUM.
REQ-017 ACCUM: in_ready=1 combinationally from state; a transfer occurs on in_valid&in_ready at a rising edge.
REQ-018 Each transfer SHALL update acc<=sat(acc +/- in_data), ovfl<=ovfl|step_overflow, remaining<=remaining-1, all on the same edge.
REQ-019 Add overflow: operand signs equal and raw-sum sign differs from acc sign.
REQ-020 Subtract overflow: acc sign differs from in_data sign and raw-difference sign differs from acc sign; this includes in_data=0x8000.
REQ-021 On overflow, acc SHALL saturate to 0x7FFF if acc[15]=0, or to 0x8000 if acc[15]=1; otherwise acc takes the 16-bit wrapped result.
REQ-022 The transfer with remaining=1 SHALL move the FSM to DONE on the same edge, so out_valid rises in the cycle after the last acceptance.
REQ-023 Cycles in ACCUM without in_valid SHALL leave acc, ovfl and remaining unchanged.
REQ-024 DONE: out_valid=1, in_ready=0; acc and ovfl are held stable until out_ready=1 at an edge, then the FSM moves to IDLE.
REQ-025 start asserted in ACCUM or DONE SHALL be ignored and SHALL NOT be queued.
REQ-026 acc and ovfl SHALL remain readable in IDLE with the last job's values until the next start clears them.
REQ-027 The 16-bit add/subtract SHALL be computed combinationally, with no added latency beyond the acc register.

Reset
REQ-028 While rst=1, the block SHALL force, immediately and independent of clk: state=IDLE, acc=0x0000, ovfl=0, remaining=0, in_ready=0, out_valid=0, busy=0.
REQ-029 Reset asserted mid-job SHALL abandon that job; no residue may affect the next job.
REQ-030 The first start SHALL be honoured at the first rising edge after rst deasserts.

Verification
REQ-031 len=2; add 0x0003, then sub 0x0001 -> acc=0x0002, ovfl=0; out_valid high the cycle after the 2nd transfer.
REQ-032 len=2; add 0x7000, then add 0x2000 -> acc=0x7FFF, ovfl=1; len=1, add 0x8000 to a fresh job -> acc=0x8000, ovfl=0.
REQ-033 len=3; sub 0x8000 (acc=0x7FFF, ovfl=1), add 0x0001 (acc stays 0x7FFF), sub 0x0001 -> final acc=0x7FFE, ovfl=1.
REQ-034 len=0; sixteen add 0x0001 with random in_valid gaps -> out_valid only after exactly 16 transfers, acc=0x0010.
REQ-035 len=4; rst pulse after 1 transfer -> all outputs reset with no clock edge; a new len=1 job adding 0x0005 -> acc=0x0005, ovfl=0.
REQ-036 In DONE, out_ready low for 5 cycles while start toggles -> acc/ovfl/out_valid stable, no new job; out_ready=1 -> IDLE next cycle, busy=0.

Source files
------------

// File: rtl/sat_accum_16bit.sv
// ---------------------------------------------------------------------------
// sat_accum_16bit
//
// A job-based saturating accumulator. A job starts from IDLE when start is
// high. It captures an operand count (len, where 0 means 2^LEN_W) and clears
// the accumulator. It then accepts that many signed 16-bit operands. Each
// operand is added to or subtracted from the accumulator with saturation.
// The final value and a sticky overflow flag are presented until the
// consumer takes them.
//
// Ports
//   clk        : clock, rising-edge active
//   rst        : asynchronous active-high reset
//   start      : job request, honoured only in IDLE
//   len        : operand count for the job (0 encodes 2^LEN_W)
//   in_valid   : operand present on in_data / in_sub
//   in_ready   : block accepts an operand this cycle (ACCUM state)
//   in_data    : two's-complement operand
//   in_sub     : 1 = subtract operand, 0 = add operand
//   out_valid  : final result valid on acc / ovfl (DONE state)
//   out_ready  : consumer takes the result
//   acc        : running or final saturated accumulator
//   ovfl       : sticky saturation flag for the current job
//   busy       : high whenever the block is not IDLE
// ---------------------------------------------------------------------------
module sat_accum_16bit #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      acc,
    output logic             ovfl,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic signed [15:0] acc_q, acc_d;
    logic               ovfl_q, ovfl_d;
    logic [LEN_W:0]     rem_q, rem_d;

    logic signed [15:0] operand;
    logic signed [15:0] raw_res;
    logic               step_ovf;
    logic signed [15:0] sat_res;

    // 16-bit wrapped add/subtract.
    function automatic logic signed [15:0] raw_step(
        input logic signed [15:0] a,
        input logic signed [15:0] b,
        input logic               sub
    );
        return sub ? (a - b) : (a + b);
    endfunction

    // Overflow is judged from sign bits only. For subtraction, the case
    // b = 0x8000 is caught naturally: it differs in sign from any
    // non-negative acc, and the wrapped result then stays negative.
    function automatic logic step_overflow(
        input logic signed [15:0] a,
        input logic signed [15:0] b,
        input logic               sub,
        input logic signed [15:0] r
    );
        if (sub)
            return (a[15] != b[15]) && (r[15] != a[15]);
        else
            return (a[15] == b[15]) && (r[15] != a[15]);
    endfunction

    // Clamp toward the side the accumulator was already on.
    function automatic logic signed [15:0] saturate(
        input logic signed [15:0] a,
        input logic signed [15:0] r,
        input logic               ovf
    );
        if (!ovf)
            return r;
        return a[15] ? 16'sh8000 : 16'sh7FFF;
    endfunction

    assign operand  = in_data;
    assign raw_res  = raw_step(acc_q, operand, in_sub);
    assign step_ovf = step_overflow(acc_q, operand, in_sub, raw_res);
    assign sat_res  = saturate(acc_q, raw_res, step_ovf);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovfl_d  = ovfl_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovfl_d  = 1'b0;
                    // A zero count selects the full 2^LEN_W operands.
                    rem_d   = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d  = sat_res;
                    ovfl_d = ovfl_q | step_ovf;
                    rem_d  = rem_q - (LEN_W+1)'(1);
                    if (rem_q == (LEN_W+1)'(1))
                        state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovfl_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovfl_q  <= ovfl_d;
            rem_q   <= rem_d;
        end
    end

    // Handshake outputs decode straight from the state register.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign acc       = acc_q;
    assign ovfl      = ovfl_q;

endmodule
